alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
- Initiator-side sequencer that drives the TotalALU command interface (dataA, dataB, 6-bit funct Signal) and collects results from its 32-bit Output.
- Accepts one request at a time over a valid/ready handshake.
- Single-cycle ops (AND/OR/ADD/SUB/SLT/SRL/MFHI/MFLO) go straight to the ALU. For DIVU it holds the DIVU code for the full divider run, then issues MFHI and MFLO, and returns quotient and remainder in one response.

Parameters:
- WIDTH, 32, data width of operands and results
- DIV_CYCLES, 32, cycles DIVU must be held on alu_signal for the divider to complete

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted on req_valid&&req_ready
- req_op  input  6  funct code
- req_a  input  WIDTH  operand A
- req_b  input  WIDTH  operand B
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed on rsp_valid&&rsp_ready
- rsp_data  output  WIDTH  result; quotient (LO) for DIVU
- rsp_hi  output  WIDTH  remainder (HI) for DIVU, 0 otherwise
- rsp_err  output  1  unsupported op or DIVU by zero
- alu_dataA  output  WIDTH  to TotalALU dataA
- alu_dataB  output  WIDTH  to TotalALU dataB
- alu_signal  output  6  to TotalALU Signal
- alu_output  input  WIDTH  from TotalALU Output
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, active-high):
  - state=IDLE, counter=0.
  - All outputs 0 except req_ready=1.
  - alu_signal=NOP (6'b000000).
  - Reset mid-operation abandons the op with no response.
- Funct codes:
  - AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, DIVU=27, MFHI=16, MFLO=18, NOP=0.
- States: IDLE, EXEC, DIV_RUN, DIV_SETTLE, RD_HI, RD_LO, RESP.
- IDLE:
  - req_ready=1. alu_signal=NOP; alu_dataA/B hold last values.
  - On accept, latch op/a/b:
    - Single-cycle op → EXEC.
    - DIVU with b!=0 → DIV_RUN with counter=0.
    - DIVU with b==0 → RESP with err=1, data=0, hi=0; the divider is never started.
    - Unknown op → RESP with err=1, data=0, hi=0.
- EXEC (1 cycle): alu_signal=op; alu_dataA/B=latched a/b. At the clock edge, rsp_data←alu_output, rsp_hi←0, err←0; → RESP.
- DIV_RUN: alu_signal=DIVU, operands held. Counter increments each cycle; after DIV_CYCLES cycles → DIV_SETTLE.
- DIV_SETTLE (1 cycle): alu_signal=NOP while HiLo latches the divider result.
- RD_HI (1 cycle): alu_signal=MFHI; rsp_hi←alu_output at the edge.
- RD_LO (1 cycle): alu_signal=MFLO; rsp_data←alu_output at the edge; err←0; → RESP.
- RESP:
  - rsp_valid=1; rsp_data/rsp_hi/rsp_err stable until handshake.
  - alu_signal=NOP; req_ready=0.
  - On rsp_ready → IDLE. A new request is accepted no earlier than the cycle after.
- Latency, counted in edges from accept edge to rsp_valid high:
  - Single-cycle op: 2.
  - DIVU: DIV_CYCLES+4, i.e. 36 at default.
  - Error paths: 1.
- No pipelining; at most one op outstanding.
- req_* inputs are ignored outside IDLE.
- alu_signal changes only at clock edges, never glitching between codes within a cycle.
- Counter is $clog2(DIV_CYCLES+1) bits and saturates; it never wraps.
- rsp_ready asserted while rsp_valid=0 has no effect.

Decomposition:
- Shared package alu_defs_pkg holds the funct-code constants (AND, OR, ADD, SUB, SLT, SRL, DIVU, MFHI, MFLO, NOP) and the state encoding, so ALUControl and this block agree on codes.
- No sub-module is needed. The FSM, counter and response registers are a single module.

Test Plan:
- ADD a=5, b=7 → rsp_valid 2 edges after accept; rsp_data=12, rsp_hi=0, rsp_err=0; alu_signal=32 for exactly 1 cycle.
- DIVU a=100, b=7 with TotalALU attached → alu_signal=27 for 32 cycles, then NOP, 16, 18. rsp_valid at edge 36 with rsp_data=14, rsp_hi=2.
- DIVU a=9, b=0 → rsp_valid after 1 edge, rsp_err=1, rsp_data=0, rsp_hi=0; alu_signal never leaves NOP.
- req_op=6'h3F → rsp_err=1, rsp_data=0.
- SUB 3−5 with rsp_ready low for 10 cycles → rsp_data=32'hFFFFFFFE held stable and req_ready=0 throughout; a second req_valid during that window is not accepted.
- Assert reset at DIV_RUN cycle 10 → all outputs return to reset values immediately, busy=0, no response. A following SLT a=−1, b=1 returns rsp_data=1.

Source files
------------

// File: rtl/alu_defs_pkg.sv
// Shared TotalALU funct codes and issue-controller state encoding, so the
// ALU control decode and the issue sequencer agree on every code.
package alu_defs_pkg;

    localparam logic [5:0] FN_NOP  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_MFHI = 6'd16;
    localparam logic [5:0] FN_MFLO = 6'd18;
    localparam logic [5:0] FN_DIVU = 6'd27;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_SLT  = 6'd42;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_EXEC       = 3'd1;
    localparam logic [2:0] ST_DIV_RUN    = 3'd2;
    localparam logic [2:0] ST_DIV_SETTLE = 3'd3;
    localparam logic [2:0] ST_RD_HI      = 3'd4;
    localparam logic [2:0] ST_RD_LO      = 3'd5;
    localparam logic [2:0] ST_RESP       = 3'd6;

    // Ops whose result appears on the ALU output in the same cycle.
    function automatic logic is_single_cycle(input logic [5:0] op);
        case (op)
            FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
            FN_SRL, FN_MFHI, FN_MFLO: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer for the TotalALU: one request at a time, single-cycle ops
// straight through, DIVU held for the divider run then read back via MFHI/MFLO.
module alu_issue_ctrl
    import alu_defs_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_dataA,
    output logic [WIDTH-1:0] alu_dataB,
    output logic [5:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_output,
    output logic             busy
);

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_CYCLES);

    logic [2:0]       state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [5:0]       signal_q,   signal_d;
    logic [WIDTH-1:0] data_a_q,   data_a_d;
    logic [WIDTH-1:0] data_b_q,   data_b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [WIDTH-1:0] rsp_hi_q,   rsp_hi_d;
    logic             rsp_err_q,  rsp_err_d;

    // NOTE: alu_signal is computed for the *next* state and registered, so the
    // ALU sees a code that only changes at clock edges and never glitches.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        signal_d   = FN_NOP;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        rsp_data_d = rsp_data_q;
        rsp_hi_d   = rsp_hi_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    data_a_d = req_a;
                    data_b_d = req_b;
                    if (is_single_cycle(req_op)) begin
                        state_d  = ST_EXEC;
                        signal_d = req_op;
                    end else if (req_op == FN_DIVU && req_b != '0) begin
                        state_d  = ST_DIV_RUN;
                        cnt_d    = '0;
                        signal_d = FN_DIVU;
                    end else begin
                        // Unknown op or divide by zero: the divider is never started.
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_hi_d   = '0;
                        rsp_err_d  = 1'b1;
                    end
                end
            end
            ST_EXEC: begin
                rsp_data_d = alu_output;
                rsp_hi_d   = '0;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_DIV_RUN: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DIV_SETTLE;
                end else begin
                    signal_d = FN_DIVU;
                end
            end
            ST_DIV_SETTLE: begin
                state_d  = ST_RD_HI;
                signal_d = FN_MFHI;
            end
            ST_RD_HI: begin
                rsp_hi_d = alu_output;
                state_d  = ST_RD_LO;
                signal_d = FN_MFLO;
            end
            ST_RD_LO: begin
                rsp_data_d = alu_output;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the async reset
    // abandons any operation in flight without producing a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            signal_q   <= FN_NOP;
            data_a_q   <= '0;
            data_b_q   <= '0;
            rsp_data_q <= '0;
            rsp_hi_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            signal_q   <= signal_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            rsp_data_q <= rsp_data_d;
            rsp_hi_q   <= rsp_hi_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_hi     = rsp_hi_q;
    assign rsp_err    = rsp_err_q;
    assign alu_dataA  = data_a_q;
    assign alu_dataB  = data_b_q;
    assign alu_signal = signal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural TotalALU attached
// (combinational ops plus a HI/LO divider that needs DIVU held for 32 cycles).
module tb_alu_issue_ctrl;

    localparam int WIDTH      = 32;
    localparam int DIV_CYCLES = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_dataA;
    logic [WIDTH-1:0] alu_dataB;
    logic [5:0]       alu_signal;
    logic [WIDTH-1:0] alu_output;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(WIDTH), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_hi     (rsp_hi),
        .rsp_err    (rsp_err),
        .alu_dataA  (alu_dataA),
        .alu_dataB  (alu_dataB),
        .alu_signal (alu_signal),
        .alu_output (alu_output),
        .busy       (busy)
    );

    // Behavioural TotalALU: HI/LO update once DIVU has been held DIV_CYCLES cycles.
    logic [WIDTH-1:0] alu_hi, alu_lo;
    int               div_run;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_hi  <= '0;
            alu_lo  <= '0;
            div_run <= 0;
        end else if (alu_signal == 6'd27) begin
            div_run <= div_run + 1;
            if (div_run == DIV_CYCLES - 1 && alu_dataB != 0) begin
                alu_hi <= alu_dataA % alu_dataB;
                alu_lo <= alu_dataA / alu_dataB;
            end
        end else begin
            div_run <= 0;
        end
    end

    always_comb begin
        alu_output = '0;
        case (alu_signal)
            6'd36: alu_output = alu_dataA & alu_dataB;
            6'd37: alu_output = alu_dataA | alu_dataB;
            6'd32: alu_output = alu_dataA + alu_dataB;
            6'd34: alu_output = alu_dataA - alu_dataB;
            6'd42: alu_output = ($signed(alu_dataA) < $signed(alu_dataB)) ? 32'd1 : 32'd0;
            6'd2:  alu_output = alu_dataA >> alu_dataB[4:0];
            6'd16: alu_output = alu_hi;
            6'd18: alu_output = alu_lo;
            default: alu_output = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int       edges;
        int       n_divu;
        int       stray;
        logic [5:0] s33, s34, s35;

        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset alu_signal", 32'(alu_signal), 32'd0);
        check("reset alu_dataA", alu_dataA, 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD 5+7: ADD code for exactly one cycle, response after 2 edges.
        issue(6'd32, 32'd5, 32'd7);
        check("add signal edge1", 32'(alu_signal), 32'd32);
        check("add busy", 32'(busy), 32'd1);
        check("add rsp_valid edge1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("add rsp_valid edge2", 32'(rsp_valid), 32'd1);
        check("add signal edge2", 32'(alu_signal), 32'd0);
        check("add rsp_data", rsp_data, 32'd12);
        check("add rsp_hi", rsp_hi, 32'd0);
        check("add rsp_err", 32'(rsp_err), 32'd0);
        take_rsp();
        check("add idle req_ready", 32'(req_ready), 32'd1);
        check("add idle busy", 32'(busy), 32'd0);

        // DIVU 100/7: 32 cycles of DIVU, then NOP, MFHI, MFLO; response at edge 36.
        issue(6'd27, 32'd100, 32'd7);
        edges  = 1;
        n_divu = 0;
        s33 = 6'h3F; s34 = 6'h3F; s35 = 6'h3F;
        while (!rsp_valid && edges < 100) begin
            if (alu_signal == 6'd27) n_divu++;
            if (edges == 33) s33 = alu_signal;
            if (edges == 34) s34 = alu_signal;
            if (edges == 35) s35 = alu_signal;
            @(negedge clk);
            edges++;
        end
        check("divu latency", 32'(edges), 32'd36);
        check("divu signal cycles", 32'(n_divu), 32'd32);
        check("divu settle nop", 32'(s33), 32'd0);
        check("divu mfhi", 32'(s34), 32'd16);
        check("divu mflo", 32'(s35), 32'd18);
        check("divu quotient", rsp_data, 32'd14);
        check("divu remainder", rsp_hi, 32'd2);
        check("divu rsp_err", 32'(rsp_err), 32'd0);
        take_rsp();

        // DIVU by zero: error after one edge, divider untouched.
        issue(6'd27, 32'd9, 32'd0);
        check("div0 rsp_valid", 32'(rsp_valid), 32'd1);
        check("div0 signal", 32'(alu_signal), 32'd0);
        check("div0 rsp_err", 32'(rsp_err), 32'd1);
        check("div0 rsp_data", rsp_data, 32'd0);
        check("div0 rsp_hi", rsp_hi, 32'd0);
        take_rsp();

        // Unknown funct code.
        issue(6'h3F, 32'd1, 32'd2);
        check("badop rsp_valid", 32'(rsp_valid), 32'd1);
        check("badop rsp_err", 32'(rsp_err), 32'd1);
        check("badop rsp_data", rsp_data, 32'd0);
        take_rsp();

        // SUB 3-5 with back-pressure and a competing request held high.
        issue(6'd34, 32'd3, 32'd5);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 6'd32;
        req_a     = 32'd1;
        req_b     = 32'd1;
        for (int i = 0; i < 10; i++) begin
            check("sub held data", rsp_data, 32'hFFFF_FFFE);
            check("sub held req_ready", 32'(req_ready), 32'd0);
            check("sub held valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
        end
        req_valid = 1'b0;
        take_rsp();
        @(negedge clk);
        check("sub no stray accept busy", 32'(busy), 32'd0);
        check("sub no stray rsp", 32'(rsp_valid), 32'd0);

        // Reset during DIV_RUN cycle 10 abandons the op.
        issue(6'd27, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        check("pre-reset signal", 32'(alu_signal), 32'd27);
        reset = 1'b1;
        #1;
        check("mid reset signal", 32'(alu_signal), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset req_ready", 32'(req_ready), 32'd1);
        check("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid reset alu_dataA", alu_dataA, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) stray++;
        end
        check("post reset quiet", 32'(stray), 32'd0);

        // SLT -1 < 1 after recovery.
        issue(6'd42, 32'hFFFF_FFFF, 32'd1);
        @(negedge clk);
        check("slt rsp_valid", 32'(rsp_valid), 32'd1);
        check("slt rsp_data", rsp_data, 32'd1);
        take_rsp();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
